// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
// Bit-serial subtractor controller. One full-subtractor slice is stepped over
// WIDTH clock cycles, LSB first, to form (a - b - bin) mod 2^WIDTH plus the
// final borrow. The borrow is carried between slices in a flop.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      request; only looked at while idle
//   a, b, bin  minuend, subtrahend, borrow-in; captured when start is accepted
//   busy       high in SHIFT and DONE
//   done       one-cycle pulse, diff/borrow_out valid
//   diff       result, held until the next completion or reset
//   borrow_out final borrow (a < b + bin, unsigned)
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one bit slice per cycle, WIDTH cycles
// DONE  | result presented for exactly one cycle
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             bo_bit;

  always_comb begin
    d_bit  = a_sh[0] ^ b_sh[0] ^ br;
    bo_bit = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    // New bit enters at the MSB; written this way so WIDTH=1 needs no special case.
    acc_next = acc >> 1;
    acc_next[WIDTH-1] = d_bit;
  end

  assign busy = (state == SHIFT) || (state == DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      acc        <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            cnt   <= '0;
            acc   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc  <= acc_next;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= bo_bit;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            // Final slice: publish the completed word so it is valid alongside done.
            diff       <= acc_next;
            borrow_out <= bo_bit;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
